// File: rtl/i4001_bank.sv
// i4001_bank: NUM_CHIPS consecutive 4001 ROM/I-O chips on one MCS-4 bus, sharing one BRAM read port.
// Optional feature macro I4001_BANK_IO_SYNC_EN: io_in passes through a 2-flop synchroniser before RDR.
module i4001_bank #(
  parameter int                     NUM_CHIPS = 4,
  parameter int                     BASE_CHIP = 0,
  parameter logic [NUM_CHIPS*4-1:0] IO_OUTPUT = '0,
  parameter logic [NUM_CHIPS*4-1:0] IO_INVERT = '0
) (
  input  logic                     sysclk,
  input  logic                     poc_n,
  input  logic                     clk1_pad,
  input  logic                     clk2_pad,
  input  logic                     sync_pad,
  input  logic                     cmrom_pad,
  input  logic [3:0]               data_pad,
  output logic [3:0]               data_out,
  output logic                     data_dir,
  input  logic                     clear_pad,
  output logic [11:0]              rom_addr,
  input  logic [7:0]               rom_data,
  input  logic [NUM_CHIPS*4-1:0]   io_in,
  output logic [NUM_CHIPS*4-1:0]   io_out,
  output logic                     locked
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  logic                   clk2_q, clk2_d;
  phase_t                 phase_q, phase_d;
  logic                   locked_q, locked_d;
  logic [7:0]             addr_q, addr_d;
  logic                   chipsel_q, chipsel_d;
  logic [11:0]            rom_addr_q, rom_addr_d;
  logic [3:0]             dout_q, dout_d;
  logic                   ddir_q, ddir_d;
  logic                   wrr_q, wrr_d;
  logic                   rdr_q, rdr_d;
  logic [3:0]             src_chip_q, src_chip_d;
  logic                   src_valid_q, src_valid_d;
  logic [NUM_CHIPS*4-1:0] io_lat_q, io_lat_d;
  logic [NUM_CHIPS*4-1:0] io_samp;
  logic                   rise, fall;
  logic [3:0]             rd_nib;

  // clk1 carries nothing the clk2-edge phase tracker needs.
  logic unused_ok;
  assign unused_ok = clk1_pad;

  // Chips below BASE_CHIP wrap the 5-bit difference to 17..31, so one compare covers both bounds.
  function automatic logic in_range(input logic [3:0] d);
    logic [4:0] diff;
    diff = {1'b0, d} - 5'(BASE_CHIP);
    return diff < 5'(NUM_CHIPS);
  endfunction

`ifdef I4001_BANK_IO_SYNC_EN
  logic [NUM_CHIPS*4-1:0] io_meta_q, io_sync_q;

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      io_meta_q <= '0;
      io_sync_q <= '0;
    end else begin
      io_meta_q <= io_in;
      io_sync_q <= io_meta_q;
    end
  end

  assign io_samp = io_sync_q;
`else
  assign io_samp = io_in;
`endif

  assign rise = clk2_pad & ~clk2_q;
  assign fall = ~clk2_pad & clk2_q;

  // RDR read-back: input pins through the inversion mask, output pins from their latch.
  always_comb begin
    rd_nib = '0;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (src_chip_q == 4'(BASE_CHIP + c)) begin
        rd_nib = ((io_samp[4*c +: 4] ^ IO_INVERT[4*c +: 4]) & ~IO_OUTPUT[4*c +: 4])
               | (io_lat_q[4*c +: 4] & IO_OUTPUT[4*c +: 4]);
      end
    end
  end

  always_comb begin
    clk2_d      = clk2_pad;
    phase_d     = phase_q;
    locked_d    = locked_q;
    addr_d      = addr_q;
    chipsel_d   = chipsel_q;
    rom_addr_d  = rom_addr_q;
    dout_d      = dout_q;
    ddir_d      = ddir_q;
    wrr_d       = wrr_q;
    rdr_d       = rdr_q;
    src_chip_d  = src_chip_q;
    src_valid_d = src_valid_q;
    io_lat_d    = io_lat_q;

    if (fall) begin
      if (sync_pad) begin
        phase_d  = PH_A1;
        locked_d = 1'b1;
        wrr_d    = 1'b0;
        rdr_d    = 1'b0;
      end else if (phase_q == PH_X3) begin
        locked_d = 1'b0;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end

      // Bus drive is decided for the phase being entered, so it is stable before its rise.
      ddir_d = 1'b0;
      dout_d = 4'h0;
      case (phase_d)
        PH_M1: if (chipsel_q) begin
          ddir_d = 1'b1;
          dout_d = rom_data[7:4];
        end
        PH_M2: if (chipsel_q) begin
          ddir_d = 1'b1;
          dout_d = rom_data[3:0];
        end
        PH_X1: if (rdr_q) begin
          ddir_d = 1'b1;
          dout_d = rd_nib;
        end
        default: ;
      endcase
    end

    if (rise && locked_q) begin
      case (phase_q)
        PH_A1: addr_d[3:0] = data_pad;
        PH_A2: addr_d[7:4] = data_pad;
        PH_A3: begin
          chipsel_d = cmrom_pad & in_range(data_pad);
          if (chipsel_d) begin
            rom_addr_d = {data_pad, addr_q};
          end
        end
        PH_M2: begin
          if (src_valid_q && cmrom_pad) begin
            if (data_pad == 4'b0010) wrr_d = 1'b1;
            if (data_pad == 4'b1010) rdr_d = 1'b1;
          end
        end
        PH_X2: begin
          if (cmrom_pad) begin
            src_chip_d  = data_pad;
            src_valid_d = in_range(data_pad);
          end
          // WRR targets the chip chosen by the previous SRC, not one arriving on this edge.
          if (wrr_q) begin
            for (int c = 0; c < NUM_CHIPS; c++) begin
              if (src_chip_q == 4'(BASE_CHIP + c)) begin
                io_lat_d[4*c +: 4] = (data_pad & IO_OUTPUT[4*c +: 4])
                                   | (io_lat_q[4*c +: 4] & ~IO_OUTPUT[4*c +: 4]);
              end
            end
          end
        end
        default: ;
      endcase
    end

    if (clear_pad) begin
      io_lat_d = '0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      clk2_q      <= 1'b0;
      phase_q     <= PH_X3;
      locked_q    <= 1'b0;
      addr_q      <= '0;
      chipsel_q   <= 1'b0;
      rom_addr_q  <= '0;
      dout_q      <= '0;
      ddir_q      <= 1'b0;
      wrr_q       <= 1'b0;
      rdr_q       <= 1'b0;
      src_chip_q  <= '0;
      src_valid_q <= 1'b0;
      io_lat_q    <= '0;
    end else begin
      clk2_q      <= clk2_d;
      phase_q     <= phase_d;
      locked_q    <= locked_d;
      addr_q      <= addr_d;
      chipsel_q   <= chipsel_d;
      rom_addr_q  <= rom_addr_d;
      dout_q      <= dout_d;
      ddir_q      <= ddir_d;
      wrr_q       <= wrr_d;
      rdr_q       <= rdr_d;
      src_chip_q  <= src_chip_d;
      src_valid_q <= src_valid_d;
      io_lat_q    <= io_lat_d;
    end
  end

  assign data_out = dout_q;
  assign data_dir = ddir_q;
  assign rom_addr = rom_addr_q;
  assign locked   = locked_q;
  assign io_out   = (io_lat_q ^ IO_INVERT) & IO_OUTPUT;

endmodule

// File: doc/i4001_bank.md
Name: i4001_bank

Overview:
Parametrised successor to the single-chip 4001 emulation. One block emulates NUM_CHIPS consecutive 4001 ROM/I-O chips that share one external block-RAM port. It contains its own phase tracker, ROM fetch logic, SRC/WRR/RDR decode and a per-chip 4-bit I/O port. It sits on the MCS-4 bus beside the 4004 core and replaces several separate single-chip instances.

Parameters:
NUM_CHIPS, 4, number of emulated chips (1..16).
BASE_CHIP, 0, chip number of the first chip; chips BASE_CHIP..BASE_CHIP+NUM_CHIPS-1 respond; BASE_CHIP+NUM_CHIPS must be <=16.
IO_OUTPUT, all 0, NUM_CHIPS*4-bit mask; bit 4c+p set means chip c pin p is an output.
IO_INVERT, all 0, NUM_CHIPS*4-bit mask; inverts the pin in both directions.

Ports:
sysclk  in  1  system clock; every flop clocks on its rising edge.
poc_n  in  1  synchronous active-low reset.
clk1_pad, clk2_pad, sync_pad, cmrom_pad  in  1 each  MCS-4 bus signals, already synchronous to sysclk.
data_pad  in  4  bus data in.
data_out  out  4  bus data out.
data_dir  out  1  high when this block drives the bus.
clear_pad  in  1  synchronous clear of all output latches.
rom_addr  out  12  {chip number, 8-bit address} to the shared BRAM.
rom_data  in  8  BRAM data, valid 1 sysclk after rom_addr changes.
io_in  in  NUM_CHIPS*4  input pins.
io_out  out  NUM_CHIPS*4  output pins; input-configured bits are driven 0.
locked  out  1  phase tracker is synchronised.

Behaviour:
- Reset (poc_n=0 at a sysclk edge) clears every register. Values after reset: phase=X3, locked=0, data_out=0, data_dir=0, rom_addr=0, io_out equals the IO_INVERT bits of output pins (latch is 0, so inverted pins read 1), chipsel=0, src_valid=0, wrr/rdr flags=0.
- Edge detection: register clk2 each cycle as clk2_q. rise = clk2 & ~clk2_q; fall = ~clk2 & clk2_q.
- Phase tracker: phases A1,A2,A3,M1,M2,X1,X2,X3 encoded 0..7.
  - On fall: if sync_pad=1, phase<=A1 and locked<=1.
  - Otherwise, if phase=X3, phase stays X3 and locked<=0 (lost sync).
  - Otherwise phase<=phase+1.
  - All bus captures below happen on rise and only while locked=1.
- A1 rise: addr[3:0]<=data_pad. A2 rise: addr[7:4]<=data_pad.
- A3 rise: chipsel<=cmrom_pad & in_range(data_pad); sel<=data_pad. in_range(d) is BASE_CHIP<=d<BASE_CHIP+NUM_CHIPS, using 5-bit unsigned compare with no wrap. rom_addr<={sel,addr}, registered on the same edge.
- Fetch output: during phases M1 and M2 with chipsel=1, data_dir=1. data_out=rom_data[7:4] in M1 and rom_data[3:0] in M2. Both are registered on fall into the phase, so the bus is valid before the next rise.
- M2 rise: if src_valid & cmrom_pad, set wrr_f when data_pad=4'b0010 and rdr_f when data_pad=4'b1010. Both flags clear on the A1 fall.
- X2 rise with cmrom_pad=1 (SRC): src_chip<=data_pad, src_valid<=in_range(data_pad). src_valid persists across cycles until the next SRC or reset.
- X1 with rdr_f=1: data_dir=1 and data_out=io_in nibble of src_chip, with IO_INVERT applied. Output-configured pins read back their latch value.
- X2 rise with wrr_f=1: io_out latch of src_chip<=data_pad; input-configured bits are ignored.
- data_dir falls on the fall that leaves M2 or X1. The block never drives in A1–A3, X2 or X3.
- clear_pad=1 clears all io_out latches at that edge and has priority over a simultaneous WRR. poc_n=0 mid-cycle aborts any drive immediately, on that edge.
- Out-of-range chip at A3 or SRC: no drive and no latch change.

Optional Feature:
I4001_BANK_IO_SYNC_EN.
- Defined: io_in passes through a 2-flop synchroniser before RDR sampling, adding 2 sysclk of latency.
- Undefined: io_in is sampled directly.

Test Plan:
1. Reset, then 3 sync-framed cycles -> locked=1 after the first sync fall; data_dir=0 throughout with cmrom_pad=0.
2. BASE_CHIP=2, fetch with A1=4'h5, A2=4'hA, A3 chip=3, cmrom=1, rom_data=8'hC7 -> rom_addr=12'h3A5; data_out=4'hC in M1 and 4'h7 in M2; data_dir=1 only in M1/M2.
3. A3 chip=1 with BASE_CHIP=2 -> data_dir stays 0 and rom_addr is unchanged.
4. SRC chip 3 at X2, next cycle OPA=4'b0010 at M2 and data=4'h9 at X2 -> chip-3 nibble of io_out=4'h9 for an all-output config; other chips unchanged. Same with clear_pad=1 at that X2 rise -> nibble=0.
5. SRC chip 2, OPA=4'b1010, io_in chip-2 nibble=4'h6, IO_INVERT nibble=4'h1 -> data_out=4'h7 in X1 with data_dir=1.
6. Omit sync for one cycle -> phase holds X3, locked=0, no captures; next sync relocks.
